hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard_pkg.sv | 17 +
 rtl/hazard_md_counter.sv | 36 +++
 rtl/hazard_scoreboard.sv | 111 +++++++++++
 tb/tb_hazard_scoreboard.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// Shared pipeline constants: multiply/divide encodings and the default
// width of the Tuse/Tnew timing fields.
package hazard_scoreboard_pkg;

  localparam int TW_DEFAULT = 3;

  localparam logic [1:0] MD_NONE = 2'b00;
  localparam logic [1:0] MD_MULT = 2'b01;
  localparam logic [1:0] MD_DIV  = 2'b10;

  // True for the two encodings that actually start the multiply/divide unit;
  // the reserved encoding behaves like no operation.
  function automatic logic is_md_op(input logic [1:0] md);
    return (md == MD_MULT) || (md == MD_DIV);
  endfunction

endpackage

// File: rtl/hazard_md_counter.sv
// Busy counter for the multiply/divide unit. It is reloaded whenever a
// mult or div sits in E and otherwise counts down to zero. Flush is not an
// input: an operation already issued keeps the unit busy until it completes.
module hazard_md_counter
  import hazard_scoreboard_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] e_md,
  output logic       md_busy
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  logic [CW-1:0] cnt;

  // Load on an md op in E (load beats decrement), else saturating countdown.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (e_md == MD_MULT) begin
      cnt <= CW'(MULT_CYCLES);
    end else if (e_md == MD_DIV) begin
      cnt <= CW'(DIV_CYCLES);
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign md_busy = (cnt != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// D-stage hazard detection for a 5-stage pipeline. Shadow records of the
// instructions in E/M/W carry destination, remaining time-to-forwardable and
// md kind; the D instruction stalls when an operand is needed before its
// producer can forward it, or when it touches HI/LO while the md unit is busy.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int TW          = TW_DEFAULT,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic [4:0]    d_rs,
  input  logic [4:0]    d_rt,
  input  logic [TW-1:0] d_rs_tuse,
  input  logic [TW-1:0] d_rt_tuse,
  input  logic [4:0]    d_a3,
  input  logic [TW-1:0] d_tnew,
  input  logic [1:0]    d_md,
  input  logic          d_md_use,
  output logic          stall,
  output logic          IFU_en,
  output logic          F2D_en,
  output logic          D2E_en,
  output logic          D2E_flush,
  output logic          E2M_en,
  output logic          M2W_en,
  output logic          md_busy
);

  // Remaining time only ever counts down, never wraps below zero.
  function automatic logic [TW-1:0] sat_dec(input logic [TW-1:0] t);
    return (t == '0) ? '0 : t - TW'(1);
  endfunction

  // A source collides with a producer when it names the same nonzero
  // register and is needed sooner than the result becomes forwardable.
  // An all-ones tuse can never be below a TW-bit tnew, so "never used" falls out.
  function automatic logic src_hazard(input logic [4:0]    src,
                                      input logic [TW-1:0] tuse,
                                      input logic [4:0]    a3,
                                      input logic [TW-1:0] tnew);
    return (a3 != 5'd0) && (a3 == src) && (tuse < tnew);
  endfunction

  // E record (_p0), M record (_p1), W record (_p2)
  logic [4:0]    a3_p0, a3_p1, a3_p2;
  logic [TW-1:0] tnew_p0, tnew_p1, tnew_p2;
  logic [1:0]    md_p0, md_p1, md_p2;

  logic rs_haz, rt_haz, md_haz;

  // Shadow record pipeline: advance with tnew countdown; stall injects a
  // bubble into E; flush squashes everything; reset beats flush.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      a3_p0 <= '0; tnew_p0 <= '0; md_p0 <= MD_NONE;
      a3_p1 <= '0; tnew_p1 <= '0; md_p1 <= MD_NONE;
      a3_p2 <= '0; tnew_p2 <= '0; md_p2 <= MD_NONE;
    end else begin
      // ---- D -> E ----
      if (stall) begin
        a3_p0 <= '0; tnew_p0 <= '0; md_p0 <= MD_NONE;
      end else begin
        a3_p0   <= d_a3;
        tnew_p0 <= d_tnew;
        md_p0   <= is_md_op(d_md) ? d_md : MD_NONE;
      end
      // ---- E -> M ----
      a3_p1   <= a3_p0;
      tnew_p1 <= sat_dec(tnew_p0);
      md_p1   <= md_p0;
      // ---- M -> W ----
      a3_p2   <= a3_p1;
      tnew_p2 <= sat_dec(tnew_p1);
      md_p2   <= md_p1;
    end
  end

  hazard_md_counter #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_md_counter (
    .clk     (clk),
    .reset   (reset),
    .e_md    (md_p0),
    .md_busy (md_busy)
  );

  // Combinational stall decision from current records and D inputs only.
  always_comb begin
    rs_haz = src_hazard(d_rs, d_rs_tuse, a3_p0, tnew_p0) ||
             src_hazard(d_rs, d_rs_tuse, a3_p1, tnew_p1) ||
             src_hazard(d_rs, d_rs_tuse, a3_p2, tnew_p2);
    rt_haz = src_hazard(d_rt, d_rt_tuse, a3_p0, tnew_p0) ||
             src_hazard(d_rt, d_rt_tuse, a3_p1, tnew_p1) ||
             src_hazard(d_rt, d_rt_tuse, a3_p2, tnew_p2);
    md_haz = (is_md_op(d_md) || d_md_use) && (is_md_op(md_p0) || md_busy);
    stall  = rs_haz || rt_haz || md_haz;
  end

  assign IFU_en    = ~stall;
  assign F2D_en    = ~stall;
  assign D2E_en    = ~stall;
  assign D2E_flush = stall;
  assign E2M_en    = 1'b1;
  assign M2W_en    = 1'b1;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: a table of single-producer cases
// plus hand-written multi-cycle sequences.
module tb_hazard_scoreboard;

  localparam int TW = 3;

  logic          clk = 1'b0;
  logic          reset, flush;
  logic [4:0]    d_rs, d_rt, d_a3;
  logic [TW-1:0] d_rs_tuse, d_rt_tuse, d_tnew;
  logic [1:0]    d_md;
  logic          d_md_use;
  logic          stall, IFU_en, F2D_en, D2E_en, D2E_flush, E2M_en, M2W_en, md_busy;

  int n_tests = 0;
  int n_fail  = 0;

  hazard_scoreboard #(.TW(TW), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .d_rs(d_rs), .d_rt(d_rt), .d_rs_tuse(d_rs_tuse), .d_rt_tuse(d_rt_tuse),
    .d_a3(d_a3), .d_tnew(d_tnew), .d_md(d_md), .d_md_use(d_md_use),
    .stall(stall), .IFU_en(IFU_en), .F2D_en(F2D_en), .D2E_en(D2E_en),
    .D2E_flush(D2E_flush), .E2M_en(E2M_en), .M2W_en(M2W_en), .md_busy(md_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string         name;
    logic [4:0]    e_a3;
    logic [TW-1:0] e_tnew;
    logic [1:0]    e_md;
    logic [4:0]    rs;
    logic [TW-1:0] rs_tuse;
    logic [4:0]    rt;
    logic [TW-1:0] rt_tuse;
    logic [1:0]    md;
    logic          md_use;
    logic          exp_stall;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic d_nop();
    d_rs = 0; d_rt = 0; d_rs_tuse = '1; d_rt_tuse = '1;
    d_a3 = 0; d_tnew = 0; d_md = 2'b00; d_md_use = 1'b0;
  endtask

  task automatic do_reset();
    d_nop();
    flush = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  // Push one producer into E (no source uses, so it never stalls itself).
  task automatic load(input logic [4:0] a3, input logic [TW-1:0] tnew, input logic [1:0] md);
    d_nop();
    d_a3 = a3; d_tnew = tnew; d_md = md;
    step();
  endtask

  initial begin
    vecs[0]  = '{"rs_lw_use",     5'd8,  3'd2, 2'b00, 5'd8,  3'd1, 5'd0,  3'd7, 2'b00, 1'b0, 1'b1};
    vecs[1]  = '{"r0_no_haz",     5'd0,  3'd2, 2'b00, 5'd0,  3'd0, 5'd0,  3'd0, 2'b00, 1'b0, 1'b0};
    vecs[2]  = '{"rs_tuse_eq",    5'd8,  3'd2, 2'b00, 5'd8,  3'd2, 5'd0,  3'd7, 2'b00, 1'b0, 1'b0};
    vecs[3]  = '{"rt_haz",        5'd8,  3'd2, 2'b00, 5'd0,  3'd7, 5'd8,  3'd0, 2'b00, 1'b0, 1'b1};
    vecs[4]  = '{"rs_other_reg",  5'd8,  3'd2, 2'b00, 5'd9,  3'd0, 5'd0,  3'd7, 2'b00, 1'b0, 1'b0};
    vecs[5]  = '{"rs_never_used", 5'd5,  3'd7, 2'b00, 5'd5,  3'd7, 5'd0,  3'd7, 2'b00, 1'b0, 1'b0};
    vecs[6]  = '{"md_div_after",  5'd0,  3'd0, 2'b01, 5'd0,  3'd7, 5'd0,  3'd7, 2'b10, 1'b0, 1'b1};
    vecs[7]  = '{"md_use_after",  5'd0,  3'd0, 2'b01, 5'd0,  3'd7, 5'd0,  3'd7, 2'b00, 1'b1, 1'b1};
    vecs[8]  = '{"md_e_only",     5'd0,  3'd0, 2'b10, 5'd0,  3'd7, 5'd0,  3'd7, 2'b00, 1'b0, 1'b0};
    vecs[9]  = '{"md_e_reserved", 5'd0,  3'd0, 2'b11, 5'd0,  3'd7, 5'd0,  3'd7, 2'b01, 1'b0, 1'b0};
    vecs[10] = '{"md_d_reserved", 5'd0,  3'd0, 2'b01, 5'd0,  3'd7, 5'd0,  3'd7, 2'b11, 1'b0, 1'b0};
    vecs[11] = '{"rt_r31",        5'd31, 3'd1, 2'b00, 5'd0,  3'd7, 5'd31, 3'd0, 2'b00, 1'b0, 1'b1};

    d_nop();
    flush = 1'b0;
    reset = 1'b1;
    #12;

    // Reset state
    reset = 1'b1;
    step();
    check("reset_stall",  {31'd0, stall},     0);
    check("reset_busy",   {31'd0, md_busy},   0);
    check("reset_ifu_en", {31'd0, IFU_en},    1);
    check("reset_f2d_en", {31'd0, F2D_en},    1);
    check("reset_d2e_en", {31'd0, D2E_en},    1);
    check("reset_d2e_fl", {31'd0, D2E_flush}, 0);
    check("reset_e2m_en", {31'd0, E2M_en},    1);
    check("reset_m2w_en", {31'd0, M2W_en},    1);
    reset = 1'b0;

    // Table: one producer in E, then a D instruction against it
    foreach (vecs[i]) begin
      do_reset();
      load(vecs[i].e_a3, vecs[i].e_tnew, vecs[i].e_md);
      d_nop();
      d_rs = vecs[i].rs; d_rs_tuse = vecs[i].rs_tuse;
      d_rt = vecs[i].rt; d_rt_tuse = vecs[i].rt_tuse;
      d_md = vecs[i].md; d_md_use = vecs[i].md_use;
      #1;
      check(vecs[i].name, {31'd0, stall}, {31'd0, vecs[i].exp_stall});
      check({vecs[i].name, "_ifu"}, {31'd0, IFU_en},    {31'd0, ~vecs[i].exp_stall});
      check({vecs[i].name, "_bub"}, {31'd0, D2E_flush}, {31'd0, vecs[i].exp_stall});
    end

    // Reserved md in E must not start the unit
    do_reset();
    load(5'd0, 3'd0, 2'b11);
    step();
    check("reserved_no_busy", {31'd0, md_busy}, 0);

    // lw-use: one stall cycle, then the producer in M no longer blocks
    do_reset();
    load(5'd8, 3'd2, 2'b00);
    d_nop(); d_rs = 5'd8; d_rs_tuse = 3'd1;
    #1;
    check("lwuse_c0_stall", {31'd0, stall}, 1);
    step();
    check("lwuse_c1_stall", {31'd0, stall}, 0);

    // Back-to-back producers of r9: E={9,1}, M={9,1}
    do_reset();
    load(5'd9, 3'd2, 2'b00);
    load(5'd9, 3'd1, 2'b00);
    d_nop(); d_rt = 5'd9; d_rt_tuse = 3'd0;
    #1;
    check("b2b_stall", {31'd0, stall}, 1);

    // mult in E, mflo in D: 6 stall cycles, md_busy for 5, issue as busy falls
    do_reset();
    load(5'd0, 3'd0, 2'b01);
    d_nop(); d_md_use = 1'b1;
    for (int k = 0; k <= 6; k++) begin
      if (k > 0) step();
      check($sformatf("mult_stall_c%0d", k), {31'd0, stall},   (k < 6) ? 1 : 0);
      check($sformatf("mult_busy_c%0d", k),  {31'd0, md_busy}, (k >= 1 && k <= 5) ? 1 : 0);
    end

    // div in E, flush at that edge: records cleared, unit busy full 10 cycles
    do_reset();
    load(5'd3, 3'd2, 2'b10);
    d_nop();
    flush = 1'b1;
    step();
    flush = 1'b0;
    d_rs = 5'd3; d_rs_tuse = 3'd0;
    #1;
    check("flush_cleared", {31'd0, stall}, 0);
    d_nop();
    for (int k = 1; k <= 11; k++) begin
      if (k > 1) step();
      check($sformatf("div_busy_c%0d", k), {31'd0, md_busy}, (k <= 10) ? 1 : 0);
    end

    // Reset while stalling with a mult in E
    do_reset();
    load(5'd8, 3'd2, 2'b01);
    d_nop(); d_rs = 5'd8; d_rs_tuse = 3'd0;
    #1;
    check("rst_pre_stall", {31'd0, stall}, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    check("rst_post_stall", {31'd0, stall},   0);
    check("rst_post_busy",  {31'd0, md_busy}, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected finish before 100000");
    $fatal(1);
  end

endmodule
